// File: rtl/rx_frame_ctrl_pkg.sv
// Shared UART receive definitions: FSM state encoding and bit timing.
// Used by the rx frame controller and its bit counter.
package rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int BITS_PER_SAMPLE = 16;
    localparam int DEF_SAMPLE_PT   = 7;

endpackage

// File: rtl/rx_frame_ctrl_bit_counter.sv
// Data bit index counter for the rx frame controller.
// Cleared on start-bit confirmation, stepped once per sampled data bit.
module rx_bit_counter #(
    parameter int DATA_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic [IW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign done = (cnt == IW'(DATA_BITS - 1));

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive frame controller: start detect, mid-bit sampling, stop check.
// Define RX_PARITY_EN to add an even-parity bit between data and stop.
module rx_frame_ctrl
    import rx_frame_ctrl_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_PT   = DEF_SAMPLE_PT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic [3:0]           bsc_count,
    output logic                 bsc_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   samp;

    state_t                 state_q, state_n;
    logic [DATA_BITS-1:0]   shift_q, shift_n;
    logic [DATA_BITS-1:0]   dout_n;
    logic [DATA_BITS:0]     shift_ext;
    logic                   dv_n, fe_n, pe_n;
    logic                   bit_clr, bit_inc, bit_done;
    logic                   par_bad;

    // Idle-high line: reset to 1 so reset release never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign samp      = bsc_en && (bsc_count == 4'(SAMPLE_PT));
    assign shift_ext = {rx_s, shift_q};

`ifdef RX_PARITY_EN
    logic par_q, par_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_n;
        end
    end

    assign par_bad = par_q ^ (^shift_q);
`else
    assign par_bad = 1'b0;
`endif

    rx_bit_counter #(
        .DATA_BITS(DATA_BITS)
    ) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bit_clr),
        .inc (bit_inc),
        .done(bit_done)
    );

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        dout_n  = data_out;
        dv_n    = 1'b0;
        fe_n    = 1'b0;
        pe_n    = 1'b0;
        bit_clr = 1'b0;
        bit_inc = 1'b0;
`ifdef RX_PARITY_EN
        par_n   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s) state_n = START;
            end
            START: begin
                if (samp) begin
                    if (!rx_s) begin
                        state_n = DATA;
                        bit_clr = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (samp) begin
                    shift_n = shift_ext[DATA_BITS:1];
                    bit_inc = 1'b1;
                    if (bit_done) begin
`ifdef RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (samp) begin
                    par_n   = rx_s;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (samp) begin
                    fe_n    = !rx_s;
                    pe_n    = par_bad;
                    dv_n    = rx_s && !par_bad;
                    state_n = IDLE;
                    if (rx_s && !par_bad) dout_n = shift_q;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            bsc_en     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_n;
            shift_q    <= shift_n;
            data_out   <= dout_n;
            data_valid <= dv_n;
            frame_err  <= fe_n;
            parity_err <= pe_n;
            bsc_en     <= (state_n != IDLE);
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Scoreboard bench for rx_frame_ctrl with a behavioural bit sample counter.
// Define RX_PARITY_EN to exercise the parity build.
module tb_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [3:0] bsc_count;
    logic       bsc_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    typedef struct packed {
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst || !bsc_en) bsc_count <= 4'd0;
        else                bsc_count <= bsc_count + 4'd1;
    end

    rx_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .bsc_count (bsc_count),
        .bsc_en    (bsc_en),
        .data_out  (data_out),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always @(negedge clk) begin
        if (!rst && (data_valid || frame_err || parity_err)) begin
            ev_t act, exp;
            act = '{data_valid, frame_err, parity_err, data_out};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got %h, want none", act);
            end else begin
                exp = q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL strobe: got v/fe/pe/d=%h, want %h",
                             act, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic v, input logic fe,
                             input logic pe, input logic [7:0] d);
        q.push_back('{v, fe, pe, d});
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored");
`endif
        send_bit(stop);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: sim time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d5a;
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_bsc_en", {31'd0, bsc_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);

        expect_ev(1'b1, 1'b0, 1'b0, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_idle("a5_idle");
        check("a5_bsc_en", {31'd0, bsc_en}, 32'd0);
        check("a5_data", {24'd0, data_out}, 32'hA5);

        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_data", {24'd0, data_out}, 32'hA5);
        check("glitch_busy", {31'd0, busy}, 32'd0);

        expect_ev(1'b0, 1'b1, 1'b0, 8'hA5);
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);
        wait_idle("ferr_idle");
        check("ferr_data", {24'd0, data_out}, 32'hA5);

        expect_ev(1'b1, 1'b0, 1'b0, 8'h00);
        expect_ev(1'b1, 1'b0, 1'b0, 8'hFF);
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_idle("b2b_idle");
        check("b2b_data", {24'd0, data_out}, 32'hFF);

        d5a = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d5a[i]);
        rx_in = d5a[4];
        repeat (8) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_bsc_en", {31'd0, bsc_en}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_data", {24'd0, data_out}, 32'd0);
        rx_in = 1'b1;
        repeat (40) @(negedge clk);

        expect_ev(1'b1, 1'b0, 1'b0, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_idle("5a_idle");
        check("5a_data", {24'd0, data_out}, 32'h5A);

`ifdef RX_PARITY_EN
        expect_ev(1'b0, 1'b0, 1'b1, 8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1);
        wait_idle("perr_idle");
        check("perr_data", {24'd0, data_out}, 32'h5A);
`endif

        expect_ev(1'b1, 1'b0, 1'b0, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_idle("81_idle");
        check("81_data", {24'd0, data_out}, 32'h81);

        repeat (20) @(negedge clk);
        check("sb_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
